maze_step_responder: RTL

//  Environment-side responder for the maze RL agent. Accepts (state, action) step

---
 rtl/maze_step_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/maze_step_responder.sv
// Maze environment step responder: accepts (state, action) requests, looks the target cell up
// in a loadable cell-code map and returns next state, reward and episode-done status.
module maze_step_responder #(
    parameter int unsigned ROWS        = 5,
    parameter int unsigned COLS        = 5,
    parameter int unsigned RW          = 8,
    parameter int          GOAL_REWARD = 100,
    parameter int          TRAP_REWARD = -100,
    parameter int          WALL_REWARD = -10,
    parameter int          STEP_REWARD = -1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          map_we,
    input  logic [6:0]    map_addr,
    input  logic [3:0]    map_wdata,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [6:0]    req_state,
    input  logic [3:0]    req_action,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [6:0]    rsp_next_state,
    output logic [RW-1:0] rsp_reward,
    output logic          rsp_done,
    output logic          rsp_err,
    output logic [15:0]   step_cnt
);

    localparam logic [7:0] CellsW = 8'(ROWS * COLS);
    localparam logic [7:0] RowsW  = 8'(ROWS);
    localparam logic [7:0] ColsW  = 8'(COLS);

    typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

    state_e      state_q;
    logic [6:0]  req_state_q;
    logic [3:0]  req_action_q;
    // Full 7-bit address space so any index is in range; only the first ROWS*COLS are written.
    logic [3:0]  map_q [128];

    logic [7:0]    state_ext;
    logic [7:0]    cur_row;
    logic [7:0]    cur_col;
    logic          blocked;
    logic [6:0]    tgt;
    logic [3:0]    code;
    logic [6:0]    lk_next;
    logic [RW-1:0] lk_reward;
    logic          lk_done;
    logic          lk_err;

    always_comb begin
        state_ext = {1'b0, req_state_q};
        cur_row   = state_ext / ColsW;
        cur_col   = state_ext % ColsW;
        blocked   = 1'b0;
        tgt       = req_state_q;
        case (req_action_q)
            4'd0: if (cur_row == 8'd0) blocked = 1'b1; else tgt = req_state_q - 7'(COLS);
            4'd1: if (cur_col == ColsW - 8'd1) blocked = 1'b1; else tgt = req_state_q + 7'd1;
            4'd2: if (cur_row == RowsW - 8'd1) blocked = 1'b1; else tgt = req_state_q + 7'(COLS);
            4'd3: if (cur_col == 8'd0) blocked = 1'b1; else tgt = req_state_q - 7'd1;
            default: blocked = 1'b1;
        endcase
        code = map_q[tgt];

        lk_next   = req_state_q;
        lk_reward = RW'(STEP_REWARD);
        lk_done   = 1'b0;
        lk_err    = 1'b0;
        if (state_ext >= CellsW) begin
            lk_err    = 1'b1;
            lk_done   = 1'b1;
            lk_reward = '0;
        end else if (req_action_q > 4'd3) begin
            lk_err = 1'b1;
        end else if (blocked || code == 4'd1) begin
            lk_reward = RW'(WALL_REWARD);
        end else if (code == 4'd2) begin
            lk_next   = tgt;
            lk_reward = RW'(GOAL_REWARD);
            lk_done   = 1'b1;
        end else if (code == 4'd3) begin
            lk_next   = tgt;
            lk_reward = RW'(TRAP_REWARD);
            lk_done   = 1'b1;
        end else begin
            lk_next = tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            req_ready      <= 1'b0;
            req_state_q    <= '0;
            req_action_q   <= '0;
            rsp_valid      <= 1'b0;
            rsp_next_state <= '0;
            rsp_reward     <= '0;
            rsp_done       <= 1'b0;
            rsp_err        <= 1'b0;
            step_cnt       <= '0;
            for (int i = 0; i < 128; i++) begin
                map_q[i] <= 4'd0;
            end
        end else begin
            // The lookup above reads map_q before this write lands: read-before-write.
            if (map_we && ({1'b0, map_addr} < CellsW)) begin
                map_q[map_addr] <= map_wdata;
            end
            case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_state_q  <= req_state;
                        req_action_q <= req_action;
                        req_ready    <= 1'b0;
                        state_q      <= StLookup;
                        if (step_cnt != 16'hFFFF) begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                    end
                end
                StLookup: begin
                    rsp_valid      <= 1'b1;
                    rsp_next_state <= lk_next;
                    rsp_reward     <= lk_reward;
                    rsp_done       <= lk_done;
                    rsp_err        <= lk_err;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= StIdle;
                        if (rsp_done) begin
                            step_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
